// File: rtl/wb_load_unit.sv
// Load unit between the MEM stage and the synchronous data memory read port.
// Aligns and extends byte/halfword/word loads and registers the result for WB.
// Word-crossing loads are either split into two back-to-back reads merged here
// (MISALIGN_EN=1) or reported as errors after a single read (MISALIGN_EN=0).
//
// Handshake: a load is transferred on a cycle where ld_valid && ld_ready; the
// requester keeps ld_valid and the request fields stable until that cycle.
// ld_ready does not depend on ld_valid.
module wb_load_unit #(
    parameter int unsigned MISALIGN_EN = 1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_func3,
    input  logic [4:0]        ld_rd,
    input  logic              flush,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              wb_err,
    output logic              busy
);

    localparam int unsigned WA_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT1 = 2'd1,
        S_WAIT2 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        func3_q, func3_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        off_q, off_d;
    logic              split_q, split_d;
    logic              mis_q, mis_d;
    logic [WA_W-1:0]   base_q, base_d;
    logic [31:0]       lo_q, lo_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              wb_err_q, wb_err_d;

    logic              accept;
    logic              second_rd;
    logic              need_split;
    logic              result_en;
    logic [4:0]        shamt;
    logic [31:0]       single_sh;
    logic [31:0]       merged_sh;
    logic [31:0]       word_sel;

    function automatic logic legal_f3(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
            default:                                legal_f3 = 1'b0;
        endcase
    endfunction

    // d already holds the addressed byte/halfword in its low bits
    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  fmt = {{24{d[7]}}, d[7:0]};
            3'b001:  fmt = {{16{d[15]}}, d[15:0]};
            3'b010:  fmt = d;
            3'b100:  fmt = {24'd0, d[7:0]};
            3'b101:  fmt = {16'd0, d[15:0]};
            default: fmt = 32'd0;
        endcase
    endfunction

    // The second word of a split load is fetched while the first returns
    assign second_rd = (state_q == S_WAIT1) && split_q && !flush;
    assign ld_ready  = rstn && !flush && !((state_q == S_WAIT1) && split_q);
    assign accept    = ld_valid && ld_ready;
    assign mem_en    = rstn && (accept || second_rd);
    assign mem_addr  = second_rd ? {base_q + WA_W'(1), 2'b00}
                                 : {ld_addr[ADDR_W-1:2], 2'b00};

    assign shamt     = {off_q, 3'b000};
    assign single_sh = mem_rdata >> shamt;
    assign merged_sh = 32'({mem_rdata, lo_q} >> shamt);
    assign word_sel  = (state_q == S_WAIT2) ? merged_sh : single_sh;

    // Word-crossing detection for the incoming request
    always_comb begin
        need_split = 1'b0;
        case (ld_func3)
            3'b001, 3'b101: need_split = (ld_addr[1:0] == 2'b11);
            3'b010:         need_split = (ld_addr[1:0] != 2'b00);
            default:        need_split = 1'b0;
        endcase
    end

    // Next state, context capture and result formatting
    always_comb begin
        state_d    = state_q;
        func3_d    = func3_q;
        rd_d       = rd_q;
        off_d      = off_q;
        split_d    = split_q;
        mis_d      = mis_q;
        base_d     = base_q;
        lo_d       = lo_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_err_d   = wb_err_q;
        result_en  = 1'b0;

        if (accept) begin
            func3_d = ld_func3;
            rd_d    = ld_rd;
            off_d   = ld_addr[1:0];
            base_d  = ld_addr[ADDR_W-1:2];
            split_d = need_split && (MISALIGN_EN != 0);
            mis_d   = need_split && (MISALIGN_EN == 0);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (split_q) begin
                    lo_d    = mem_rdata;
                    state_d = S_WAIT2;
                end else begin
                    result_en = 1'b1;
                    state_d   = accept ? S_WAIT1 : S_IDLE;
                end
            end
            S_WAIT2: begin
                result_en = 1'b1;
                state_d   = accept ? S_WAIT1 : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (result_en) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            if (!legal_f3(func3_q) || mis_q) begin
                wb_data_d = 32'd0;
                wb_err_d  = 1'b1;
            end else begin
                wb_data_d = fmt(func3_q, word_sel);
                wb_err_d  = 1'b0;
            end
        end

        // Flush kills every in-flight load; the visible wb_* are left as they are
        if (flush) begin
            state_d    = S_IDLE;
            wb_valid_d = 1'b0;
            wb_rd_d    = wb_rd_q;
            wb_data_d  = wb_data_q;
            wb_err_d   = wb_err_q;
        end
    end

    // State, context and result registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            func3_q    <= 3'd0;
            rd_q       <= 5'd0;
            off_q      <= 2'd0;
            split_q    <= 1'b0;
            mis_q      <= 1'b0;
            base_q     <= '0;
            lo_q       <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            func3_q    <= func3_d;
            rd_q       <= rd_d;
            off_q      <= off_d;
            split_q    <= split_d;
            mis_q      <= mis_d;
            base_q     <= base_d;
            lo_q       <= lo_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_err   = wb_err_q;
    assign busy     = (state_q != S_IDLE);

endmodule
